// File: rtl/scoreboard_register_file.sv
// Scoreboarded architectural register file for the pipelined core.
// Holds NREGS x XLEN registers (r0 hardwired to zero) plus one saturating
// in-flight-write counter per register. Decode reads two operands
// combinationally and may issue one destination per cycle; writeback retires
// one write per cycle. A RAW hazard or a saturated counter raises stall.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs1/rs2, rs1_use/rs2_use   decode operand addresses and use flags
//   rs1_dout/rs2_dout          combinational read data (optional bypass)
//   issue_valid, issue_rd      issuing instruction and its destination
//   rd, rd_din, write_enable   writeback port
//   stall                      combinational decode hold
//   dbg_addr, dbg_dout         raw storage read, no bypass
module scoreboard_register_file #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NREGS    = 32,
   parameter int unsigned     AW       = $clog2(NREGS),
   parameter int unsigned     SP_INDEX = 2,
   parameter logic [XLEN-1:0] SP_INIT  = XLEN'(32'h2ffc),
   parameter int unsigned     BYPASS   = 1,
   parameter int unsigned     CNT_W    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic            rs1_use,
   input  logic            rs2_use,
   output logic [XLEN-1:0] rs1_dout,
   output logic [XLEN-1:0] rs2_dout,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] rd_din,
   input  logic            write_enable,
   output logic            stall,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_dout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [XLEN-1:0]  rf  [NREGS];
   logic [CNT_W-1:0] cnt [NREGS];
   logic [NREGS-1:0] clr_vec;
   logic [NREGS-1:0] inc_vec;
   logic             issue_accept;

   // Register still has an outstanding write once this cycle's writeback is
   // accounted for; without bypass the retiring write only counts next cycle.
   function automatic logic pending(input logic [CNT_W-1:0] c, input logic clr);
      if ((BYPASS != 0) && clr) pending = (c > CNT_W'(1));
      else                      pending = (c != '0);
   endfunction

   // Per-register writeback hit (never for r0)
   always_comb begin
      clr_vec = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         clr_vec[i] = write_enable && (rd == AW'(i));
      end
   end

   // Hazard detection and issue acceptance
   always_comb begin
      stall = 1'b0;
      if (!reset) begin
         stall = (rs1_use && (rs1 != '0) && pending(cnt[rs1], clr_vec[rs1])) ||
                 (rs2_use && (rs2 != '0) && pending(cnt[rs2], clr_vec[rs2])) ||
                 (issue_valid && (issue_rd != '0) &&
                  (cnt[issue_rd] == CNT_MAX) && !clr_vec[issue_rd]);
      end
   end

   assign issue_accept = issue_valid && !stall && (issue_rd != '0) && !reset;

   always_comb begin
      inc_vec = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         inc_vec[i] = issue_accept && (issue_rd == AW'(i));
      end
   end

   // Read ports; clr_vec already implies rd matches and is non-zero
   assign rs1_dout = (rs1 == '0) ? '0 :
                     ((BYPASS != 0) && clr_vec[rs1]) ? rd_din : rf[rs1];
   assign rs2_dout = (rs2 == '0) ? '0 :
                     ((BYPASS != 0) && clr_vec[rs2]) ? rd_din : rf[rs2];
   assign dbg_dout = rf[dbg_addr];

   // Storage and scoreboard counters; issue and retire to the same register
   // cancel, and a stray retire to an idle register leaves its count at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            rf[i]  <= (i == SP_INDEX) ? SP_INIT : '0;
            cnt[i] <= '0;
         end
      end else begin
         if (write_enable && (rd != '0)) rf[rd] <= rd_din;
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (inc_vec[i] && !clr_vec[i])
               cnt[i] <= cnt[i] + CNT_W'(1);
            else if (clr_vec[i] && !inc_vec[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Testbench for scoreboard_register_file: directed hazard scenarios followed
// by random traffic, all compared against a behavioural model of the
// register contents and per-register in-flight counts.
module tb_scoreboard_register_file;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned AW     = 5;
   localparam int unsigned SP_IDX = 2;
   localparam logic [31:0] SP_VAL = 32'h2ffc;
   localparam int          CMAX   = 3;
   localparam bit          BYP    = 1'b1;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   rs1, rs2, issue_rd, rd, dbg_addr;
   logic            rs1_use, rs2_use, issue_valid, write_enable;
   logic [XLEN-1:0] rd_din;
   logic [XLEN-1:0] rs1_dout, rs2_dout, dbg_dout;
   logic            stall;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_rf  [NREGS];
   int          m_cnt [NREGS];

   scoreboard_register_file dut (
      .clk          (clk),
      .reset        (reset),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_use      (rs1_use),
      .rs2_use      (rs2_use),
      .rs1_dout     (rs1_dout),
      .rs2_dout     (rs2_dout),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .rd           (rd),
      .rd_din       (rd_din),
      .write_enable (write_enable),
      .stall        (stall),
      .dbg_addr     (dbg_addr),
      .dbg_dout     (dbg_dout)
   );

   always #5 clk = ~clk;

   function automatic bit hits(input int a);
      return write_enable && (int'(rd) == a) && (a != 0);
   endfunction

   function automatic logic [31:0] exp_read(input int a);
      if (a == 0) return 32'h0;
      if (BYP && hits(a)) return rd_din;
      return m_rf[a];
   endfunction

   function automatic bit exp_stall();
      int p1, p2;
      bit s;
      if (reset) return 1'b0;
      p1 = m_cnt[rs1] - ((BYP && hits(int'(rs1))) ? 1 : 0);
      p2 = m_cnt[rs2] - ((BYP && hits(int'(rs2))) ? 1 : 0);
      s = (rs1_use && rs1 != 0 && p1 > 0) || (rs2_use && rs2 != 0 && p2 > 0) ||
          (issue_valid && issue_rd != 0 && m_cnt[issue_rd] == CMAX && !hits(int'(issue_rd)));
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, check combinational outputs, then clock and
   // advance the model.
   task automatic step(input bit rst, input int r1, input bit u1, input int r2, input bit u2,
                       input bit iv, input int ird, input bit we, input int wrd,
                       input logic [31:0] din, input int dbg, input string tag);
      bit s, accept;
      reset = rst; rs1 = AW'(r1); rs1_use = u1; rs2 = AW'(r2); rs2_use = u2;
      issue_valid = iv; issue_rd = AW'(ird); write_enable = we; rd = AW'(wrd);
      rd_din = din; dbg_addr = AW'(dbg);
      #2;
      s = exp_stall();
      check({tag, ".rs1"},   rs1_dout, exp_read(r1));
      check({tag, ".rs2"},   rs2_dout, exp_read(r2));
      check({tag, ".stall"}, {31'h0, stall}, {31'h0, s});
      check({tag, ".dbg"},   dbg_dout, m_rf[dbg]);
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            m_rf[i] = (i == SP_IDX) ? SP_VAL : 32'h0;
            m_cnt[i] = 0;
         end
      end else begin
         accept = iv && !s && ird != 0;
         for (int i = 1; i < NREGS; i++) begin
            bit inc, clr;
            inc = accept && ird == i;
            clr = hits(i);
            if (inc && !clr) m_cnt[i]++;
            else if (clr && !inc && m_cnt[i] > 0) m_cnt[i]--;
         end
         if (we && wrd != 0) m_rf[wrd] = din;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) begin
         m_rf[i] = 32'h0;
         m_cnt[i] = 0;
      end
      @(negedge clk);
      // reset and reset contents
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, "rst");
      step(0, 2, 1, 0, 1, 0, 0, 0, 0, 32'h0, 5, "post_rst");
      check("sp_value", m_rf[SP_IDX], 32'h2ffc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2, "dbg_sp");
      // RAW hazard on r5 resolved by bypassed writeback
      step(0, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0, 0, "issue5");
      step(0, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0, 5, "raw5");
      check("raw5_stall_hi", {31'h0, stall}, 32'h1);
      step(0, 5, 1, 0, 0, 0, 0, 1, 5, 32'hdeadbeef, 5, "wb5");
      step(0, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0, 5, "after5");
      // r0 writes discarded, r0 issue never counted
      step(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h1234, 0, "wr0");
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, "iss0");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, "rd0");
      // saturation on r7
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0, 7, "iss7");
      step(0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0, 7, "sat7");
      check("sat7_cnt", m_cnt[7], 3);
      step(0, 0, 0, 0, 0, 1, 7, 1, 7, 32'h77, 7, "sat7_wb");
      check("sat7_cnt_wb", m_cnt[7], 3);
      for (int k = 0; k < 3; k++) step(0, 7, 1, 0, 0, 0, 0, 1, 7, 32'h70 + k, 7, "drain7");
      step(0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0, 7, "idle7");
      // use flag gating and reset flush
      step(0, 0, 0, 9, 0, 1, 9, 0, 0, 32'h0, 9, "iss9");
      step(0, 0, 0, 9, 0, 0, 0, 0, 0, 32'h0, 9, "nouse9");
      step(0, 0, 0, 9, 1, 0, 0, 0, 0, 32'h0, 9, "use9");
      step(1, 0, 0, 9, 1, 1, 9, 1, 9, 32'h99, 9, "rst9");
      step(0, 0, 0, 9, 1, 0, 0, 0, 0, 32'h0, 9, "flush9");
      // stray writeback to idle r4
      step(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'ha5, 4, "stray4");
      step(0, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0, 4, "iss4");
      step(0, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0, 4, "raw4");
      step(0, 4, 1, 0, 0, 0, 0, 1, 4, 32'h44, 4, "wb4");
      step(0, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0, 4, "after4");
      // random traffic over a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 7), 1'($urandom),
              $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
              1'($urandom), $urandom_range(0, 7), $urandom, $urandom_range(0, 7), "rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
